shift_unit: RTL

- Parametrised multi-cycle shifter for the bus-based CPU datapath; successor to the single-counter shift control block.
- Holds an operand register and a shift-count register, both loaded from the shared tri-state bus.
- Shifts one bit per clock in one of four modes and signals completion with a one-cycle done pulse.
- Drives the result back onto the bus on request.

---
 rtl/shift_unit.sv | 69 ++++++
 1 files changed

// File: rtl/shift_unit.sv
// shift_unit: bus-loaded multi-cycle shifter (SHR/SHRA/SHL/SHC), one bit per clock, done pulse on completion.
module shift_unit #(
  parameter int W     = 32,
  parameter int CNT_W = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire  [W-1:0]     bus,
  input  logic             ld_val,
  input  logic             ld_cnt,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic             out_en,
  output logic             busy,
  output logic             done,
  output logic             n,
  output logic [CNT_W-1:0] tb_shifts
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q, state_d;
  logic [W-1:0]     op_q, op_d, op_sh;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  assign op_sh = mode_q == 2'b00 ? {1'b0, op_q[W-1:1]} :
                 mode_q == 2'b01 ? {op_q[W-1], op_q[W-1:1]} :
                 mode_q == 2'b10 ? {op_q[W-2:0], 1'b0} :
                                   {op_q[W-2:0], op_q[W-1]};
  // start sees the count as updated by a coincident ld_cnt
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        op_d  = ld_val ? bus : op_q;
        cnt_d = ld_cnt ? bus[CNT_W-1:0] : cnt_q;
        if (start) begin
          mode_d  = mode;
          state_d = cnt_d != '0 ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        op_d    = op_sh;
        cnt_d   = cnt_q != '0 ? cnt_q - CNT_W'(1) : cnt_q;
        state_d = cnt_q <= CNT_W'(1) ? DONE : SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end
  assign busy      = state_q == SHIFT;
  assign done      = state_q == DONE;
  assign n         = cnt_q == '0;
  assign tb_shifts = cnt_q;
  assign bus       = (rst && out_en && state_q != SHIFT) ? op_q : {W{1'bz}};
endmodule
